// File: rtl/i2s_pkg.sv
// i2s_pkg: shared mode encodings, frame default and saturating add for the I2S frame scheduler.
package i2s_pkg;

    typedef enum logic [1:0] {
        I2S_MODE_SRC0 = 2'd0,
        I2S_MODE_SRC1 = 2'd1,
        I2S_MODE_RR   = 2'd2,
        I2S_MODE_MIX  = 2'd3
    } i2s_mode_e;

    localparam int I2S_FRAME_BITS = 64;

    // Operands are sign-extended samples of width bits (bits <= 32); result is clamped to that width's range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int bits);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = {a[31], a} + {b[31], b};
        hi = (33'sd1 <<< (bits - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (bits - 1));
        return (s > hi) ? hi[31:0] : (s < lo) ? lo[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/i2s_sample_slot.sv
// i2s_sample_slot: one-entry stereo sample buffer with registered ready, cleared whenever the scheduler is disabled.
module i2s_sample_slot #(
    parameter int W = 24
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         consume_i,
    input  logic         valid_i,
    input  logic [W-1:0] left_i,
    input  logic [W-1:0] right_i,
    output logic         ready_o,
    output logic         full_o,
    output logic [W-1:0] left_o,
    output logic [W-1:0] right_o
);

    logic         full_q, full_d, ready_q, accept;
    logic [W-1:0] left_q, right_q;

    assign accept = valid_i & ready_q & en_i;

    // No bypass: a consumed slot reopens only on the following cycle.
    always_comb full_d = (!en_i || consume_i) ? 1'b0 : (accept ? 1'b1 : full_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= en_i & ~full_d;
            if (accept) begin
                left_q  <= left_i;
                right_q <= right_i;
            end
        end
    end

    assign ready_o = ready_q;
    assign full_o  = full_q;
    assign left_o  = left_q;
    assign right_o = right_q;

endmodule

// File: rtl/i2s_frame_sched.sv
// i2s_frame_sched: bit-slot counter, lrclk strobe and per-frame source select/mix for a frame-based I2S transmitter.
module i2s_frame_sched
    import i2s_pkg::*;
#(
    parameter int BITSIZE    = 24,
    parameter int FRAME_BITS = I2S_FRAME_BITS
) (
    input  logic               sclk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [1:0]         mode_i,
    input  logic               hold_last_i,
    input  logic               s0_valid_i,
    input  logic               s1_valid_i,
    output logic               s0_ready_o,
    output logic               s1_ready_o,
    input  logic [BITSIZE-1:0] s0_left_i,
    input  logic [BITSIZE-1:0] s0_right_i,
    input  logic [BITSIZE-1:0] s1_left_i,
    input  logic [BITSIZE-1:0] s1_right_i,
    output logic               lrclk_o,
    output logic [BITSIZE-1:0] left_chan_o,
    output logic [BITSIZE-1:0] right_chan_o,
    output logic [15:0]        underrun_cnt_o,
    output logic               frame_tick_o
);

    localparam int BCW = $clog2(FRAME_BITS);
    localparam logic [BCW-1:0] BC_COMMIT = BCW'(FRAME_BITS - 2);
    localparam logic [BCW-1:0] BC_LAST   = BCW'(FRAME_BITS - 1);

    logic [BCW-1:0]     bc_q, bc_d;
    logic               lrclk_q, tick_q, last_grant_q, grant_d;
    logic [BITSIZE-1:0] left_q, right_q, new_l, new_r, mix_l, mix_r;
    logic [BITSIZE-1:0] l0, r0, l1, r1;
    logic [15:0]        cnt_q;
    logic               full0, full1, take0, take1, underrun, commit;
    i2s_mode_e          mode;

    i2s_sample_slot #(.W(BITSIZE)) u_slot0 (
        .clk_i(sclk_i), .rst_i(rst_i), .en_i(en_i), .consume_i(commit & take0),
        .valid_i(s0_valid_i), .left_i(s0_left_i), .right_i(s0_right_i),
        .ready_o(s0_ready_o), .full_o(full0), .left_o(l0), .right_o(r0)
    );

    i2s_sample_slot #(.W(BITSIZE)) u_slot1 (
        .clk_i(sclk_i), .rst_i(rst_i), .en_i(en_i), .consume_i(commit & take1),
        .valid_i(s1_valid_i), .left_i(s1_left_i), .right_i(s1_right_i),
        .ready_o(s1_ready_o), .full_o(full1), .left_o(l1), .right_o(r1)
    );

    assign mode   = i2s_mode_e'(mode_i);
    assign commit = en_i && bc_q == BC_COMMIT;

    always_comb bc_d = !en_i ? '0 : (bc_q == BC_LAST) ? '0 : bc_q + 1'b1;

    // last_grant_q=1 means src1 was served last, so src0 wins a round-robin tie.
    always_comb begin
        take0    = (mode == I2S_MODE_SRC0 || mode == I2S_MODE_MIX) ? full0 :
                   (mode == I2S_MODE_RR) ? full0 & (~full1 | last_grant_q) : 1'b0;
        take1    = (mode == I2S_MODE_SRC1 || mode == I2S_MODE_MIX) ? full1 :
                   (mode == I2S_MODE_RR) ? full1 & ~take0 : 1'b0;
        underrun = ~take0 & ~take1;
        mix_l    = BITSIZE'(sat_add(32'($signed(take0 ? l0 : {BITSIZE{1'b0}})),
                                    32'($signed(take1 ? l1 : {BITSIZE{1'b0}})), BITSIZE));
        mix_r    = BITSIZE'(sat_add(32'($signed(take0 ? r0 : {BITSIZE{1'b0}})),
                                    32'($signed(take1 ? r1 : {BITSIZE{1'b0}})), BITSIZE));
        new_l    = underrun ? (hold_last_i ? left_q : '0) : mix_l;
        new_r    = underrun ? (hold_last_i ? right_q : '0) : mix_r;
        grant_d  = (mode == I2S_MODE_RR && !underrun) ? take1 : last_grant_q;
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            bc_q         <= '0;
            lrclk_q      <= 1'b0;
            tick_q       <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            bc_q    <= bc_d;
            lrclk_q <= en_i && bc_d == BC_LAST;
            tick_q  <= en_i && bc_d == BC_COMMIT;
            if (commit) begin
                left_q       <= new_l;
                right_q      <= new_r;
                cnt_q        <= cnt_q + 16'(underrun && cnt_q != 16'hFFFF);
                last_grant_q <= grant_d;
            end
        end
    end

    assign lrclk_o        = lrclk_q;
    assign frame_tick_o   = tick_q;
    assign left_chan_o    = left_q;
    assign right_chan_o   = right_q;
    assign underrun_cnt_o = cnt_q;

endmodule

// File: tb/tb_i2s_frame_sched.sv
// tb_i2s_frame_sched: directed self-checking bench for i2s_frame_sched with BITSIZE=24, FRAME_BITS=64.
module tb_i2s_frame_sched;

    logic        sclk = 1'b0;
    logic        rst, en, hold_last, s0_valid, s1_valid;
    logic [1:0]  mode;
    logic [23:0] s0_left, s0_right, s1_left, s1_right;
    logic        s0_ready, s1_ready, lrclk, frame_tick;
    logic [23:0] left_chan, right_chan;
    logic [15:0] underrun_cnt;
    int          errors = 0;
    int          checks = 0;
    int          bc = 0;
    int          n;

    i2s_frame_sched #(.BITSIZE(24), .FRAME_BITS(64)) dut (
        .sclk_i(sclk), .rst_i(rst), .en_i(en), .mode_i(mode), .hold_last_i(hold_last),
        .s0_valid_i(s0_valid), .s1_valid_i(s1_valid), .s0_ready_o(s0_ready), .s1_ready_o(s1_ready),
        .s0_left_i(s0_left), .s0_right_i(s0_right), .s1_left_i(s1_left), .s1_right_i(s1_right),
        .lrclk_o(lrclk), .left_chan_o(left_chan), .right_chan_o(right_chan),
        .underrun_cnt_o(underrun_cnt), .frame_tick_o(frame_tick)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; the bench's own bit-slot model advances with the inputs seen at that edge.
    task automatic tick();
        int nb;
        nb = rst ? 0 : !en ? 0 : (bc == 63) ? 0 : bc + 1;
        @(posedge sclk);
        #1;
        bc = nb;
    endtask

    task automatic go_to(input int target);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (bc != target && k < 200);
        chk("go_to_bound", 32'(bc), 32'(target));
    endtask

    initial begin
        rst = 1; en = 1; mode = 2'd0; hold_last = 1;
        s0_valid = 0; s1_valid = 0;
        s0_left = '0; s0_right = '0; s1_left = '0; s1_right = '0;
        tick(); tick();
        chk("rst_lrclk", 32'(lrclk), 0);
        chk("rst_left", 32'(left_chan), 0);
        chk("rst_right", 32'(right_chan), 0);
        chk("rst_cnt", 32'(underrun_cnt), 0);
        chk("rst_ready", 32'({s0_ready, s1_ready}), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        rst = 0;
        tick();
        chk("ready_after_rst", 32'(s0_ready), 1);

        // Mode 0 single sample
        s0_valid = 1; s0_left = 24'h123456; s0_right = 24'hABCDEF;
        tick();
        s0_valid = 0;
        chk("m0_ready_drop", 32'(s0_ready), 0);
        go_to(62);
        chk("m0_lrclk_62", 32'(lrclk), 0);
        chk("m0_tick_62", 32'(frame_tick), 1);
        tick();
        chk("m0_lrclk_63", 32'(lrclk), 1);
        chk("m0_left", 32'(left_chan), 32'h123456);
        chk("m0_right", 32'(right_chan), 32'hABCDEF);
        chk("m0_cnt", 32'(underrun_cnt), 0);
        chk("m0_reready", 32'(s0_ready), 1);
        n = 0;
        repeat (64) begin
            tick();
            n += int'(lrclk);
        end
        chk("lrclk_per_frame", 32'(n), 1);
        chk("m0_hold_left", 32'(left_chan), 32'h123456);
        chk("m0_cnt_1", 32'(underrun_cnt), 1);

        // Round-robin with both producers always offering
        mode = 2'd2;
        s0_valid = 1; s0_left = 24'd1; s0_right = 24'd1;
        s1_valid = 1; s1_left = 24'd2; s1_right = 24'd2;
        go_to(63); chk("rr_0", 32'(left_chan), 1);
        go_to(63); chk("rr_1", 32'(left_chan), 2);
        chk("rr_1r", 32'(right_chan), 2);
        go_to(63); chk("rr_2", 32'(left_chan), 1);
        go_to(63); chk("rr_3", 32'(left_chan), 2);
        chk("rr_cnt", 32'(underrun_cnt), 1);
        s0_valid = 0; s1_valid = 0;

        // Disable clears slots, keeps outputs and count
        en = 0;
        tick(); tick();
        chk("dis_lrclk", 32'(lrclk), 0);
        chk("dis_left", 32'(left_chan), 2);
        chk("dis_cnt", 32'(underrun_cnt), 1);
        chk("dis_ready", 32'({s0_ready, s1_ready}), 0);
        en = 1;
        tick();
        chk("en_ready", 32'({s0_ready, s1_ready}), 32'b11);

        // Mix with saturation on both channels
        mode = 2'd3;
        s0_valid = 1; s0_left = 24'h7FFFFF; s0_right = 24'h800000;
        s1_valid = 1; s1_left = 24'h000001; s1_right = 24'hFFFFFF;
        tick();
        s0_valid = 0; s1_valid = 0;
        chk("mix_full", 32'({s0_ready, s1_ready}), 0);
        go_to(63);
        chk("mix_left", 32'(left_chan), 32'h7FFFFF);
        chk("mix_right", 32'(right_chan), 32'h800000);
        chk("mix_cnt", 32'(underrun_cnt), 1);
        tick();
        chk("mix_consumed", 32'({s0_ready, s1_ready}), 32'b11);

        // Underrun hold / zero
        mode = 2'd0;
        s0_valid = 1; s0_left = 24'h000010; s0_right = 24'h000010;
        tick();
        s0_valid = 0;
        go_to(63);
        chk("hold_seed", 32'(left_chan), 32'h10);
        go_to(63); go_to(63); go_to(63);
        chk("hold_left", 32'(left_chan), 32'h10);
        chk("hold_right", 32'(right_chan), 32'h10);
        chk("hold_cnt", 32'(underrun_cnt), 4);
        hold_last = 0;
        go_to(63);
        chk("zero_left", 32'(left_chan), 0);
        chk("zero_right", 32'(right_chan), 0);
        chk("zero_cnt", 32'(underrun_cnt), 5);

        // Sample offered at the commit slot misses this frame
        go_to(62);
        chk("bnd_ready", 32'(s0_ready), 1);
        s0_valid = 1; s0_left = 24'h000055; s0_right = 24'h000066;
        tick();
        s0_valid = 0;
        chk("bnd_miss", 32'(left_chan), 0);
        chk("bnd_cnt", 32'(underrun_cnt), 6);
        chk("bnd_taken", 32'(s0_ready), 0);
        go_to(63);
        chk("bnd_next_l", 32'(left_chan), 32'h55);
        chk("bnd_next_r", 32'(right_chan), 32'h66);
        chk("bnd_cnt2", 32'(underrun_cnt), 6);

        // Reset mid-frame with both slots full
        tick();
        s0_valid = 1; s1_valid = 1; s0_left = 24'h77; s1_left = 24'h77;
        tick();
        s0_valid = 0; s1_valid = 0;
        go_to(30);
        chk("mid_full", 32'({s0_ready, s1_ready}), 0);
        rst = 1;
        tick();
        chk("mid_ready", 32'({s0_ready, s1_ready}), 0);
        chk("mid_left", 32'(left_chan), 0);
        chk("mid_cnt", 32'(underrun_cnt), 0);
        chk("mid_lrclk", 32'(lrclk), 0);
        rst = 0;
        n = 0;
        while (!lrclk && n < 100) begin
            tick();
            n++;
        end
        chk("rst_to_lrclk", 32'(n), 63);
        chk("post_rst_cnt", 32'(underrun_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_frame_sched.md
# i2s_frame_sched

Frame scheduler and source arbiter for the 64-bit-frame I2S transmitter. It runs on the bit clock and counts bit slots to generate the one-cycle `lrclk` load strobe the transmitter expects. Two independent sample producers (e.g. synth voice bus and passthrough path) are buffered here, and each frame one stereo word is selected or mixed according to `mode`. The result is presented on stable `left_chan`/`right_chan` registers ahead of the strobe. Missed frames are counted.

## Interface
- `BITSIZE`, 24: sample width per channel, two's complement.
- `FRAME_BITS`, 64: bit-clock cycles per stereo frame; must be ≥ 2*BITSIZE and ≥ 4.
- `sclk` in 1: bit clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: scheduler enable.
- `mode` in 2: 0 = src0 only, 1 = src1 only, 2 = round-robin, 3 = mix.
- `hold_last` in 1: on underrun, 1 = repeat the previous output word, 0 = output zero.
- `s0_valid`, `s1_valid` in 1: producer offers a sample.
- `s0_ready`, `s1_ready` out 1: slot can accept.
- `s0_left`, `s0_right`, `s1_left`, `s1_right` in BITSIZE: sample data.
- `lrclk` out 1: transmitter load strobe.
- `left_chan`, `right_chan` out BITSIZE: word to transmit.
- `underrun_cnt` out 16: saturating count of frames with no usable sample.
- `frame_tick` out 1: one-cycle pulse, coincident with commit.

## Operation
- Bit counter `bc` counts 0 to FRAME_BITS-1, then wraps to 0. It advances only while `en`=1. When `en`=0 it is forced to 0.
- Commit happens at `bc`==FRAME_BITS-2 with `en`=1. The strobe is `lrclk` = 1 exactly when `bc`==FRAME_BITS-1 and `en`=1.
- Each source has a one-entry slot. Slot behaviour:
  - Accept: `sN_valid & sN_ready` writes the slot and sets it full.
  - Ready: `sN_ready` = ~full & `en`. There is no bypass. A slot consumed at commit shows ready again on the next cycle.
- Selection at commit, by `mode`:
  - Mode 0 and mode 1: consume the named slot if it is full; otherwise underrun. The other slot is untouched and keeps back-pressuring.
  - Mode 2: prefer the source after `last_grant`; if only one slot is full, take it; update `last_grant` to the taken source. If neither slot is full, underrun and leave `last_grant` unchanged.
  - Mode 3 (mix), per channel: sum of the full slots' samples, sign-extended by 1 bit and saturated to [−2^(BITSIZE-1), 2^(BITSIZE-1)−1]. An empty slot contributes 0. Both full slots are consumed. Underrun only if neither slot is full.
- Underrun:
  - Outputs become the previous word if `hold_last`=1, otherwise 0.
  - `underrun_cnt` increments and saturates at 0xFFFF.
- `mode` and `hold_last` are sampled only at commit. Changes in mid-frame take effect at the next commit.
- `en` falling:
  - `bc` clears and both slots clear on the next edge.
  - `left_chan`/`right_chan` keep their value.
  - `underrun_cnt` and `last_grant` are kept.

## Timing
- Reset values: `bc`=0, slots empty, `s0_ready`=`s1_ready`=0 during reset, `lrclk`=0, `left_chan`=`right_chan`=0, `underrun_cnt`=0, `frame_tick`=0, `last_grant`=1 (so src0 wins the first round-robin tie).
- All outputs are registered.
- `left_chan`/`right_chan` update on the edge ending the commit cycle. They are stable for the whole `lrclk` cycle and for FRAME_BITS-1 cycles after it.
- Latency: a sample accepted at `bc`≤FRAME_BITS-3 goes out at that frame's commit. A sample accepted at `bc`=FRAME_BITS-2 goes out at the next frame's commit.
- Producers fill at most one word per slot per frame. Throughput is one stereo word per FRAME_BITS cycles.
- Reset mid-frame: all state returns to reset values on the same edge, with no partial strobe.
- `en` rising: first commit at `bc`=FRAME_BITS-2, i.e. FRAME_BITS-2 cycles after enable; first `lrclk` one cycle later.

## Structure
- Shared package `i2s_pkg` holds:
  - mode encodings `I2S_MODE_SRC0/SRC1/RR/MIX`;
  - default `I2S_FRAME_BITS`=64;
  - saturating-add function `sat_add`.
- Sub-module `i2s_sample_slot` (one-entry buffer with valid/ready, clear, consume) is instantiated twice.
- Counter, arbiter and mix logic live in the top module.

## Test plan
- Mode 0, src0 supplies L=0x123456, R=0xABCDEF before `bc`=62 → `left_chan`/`right_chan` equal those values at `bc`=63, `lrclk`=1 exactly one cycle per 64, `underrun_cnt`=0.
- Mode 2, both slots held full every frame (src0 values 1/1, src1 values 2/2) → outputs alternate src0, src1, src0, … starting with src0 after reset.
- Mode 3, src0 L=0x7FFFFF, src1 L=0x000001, src0 R=0x800000, src1 R=0xFFFFFF → L=0x7FFFFF, R=0x800000 (both saturated). Both slots are consumed.
- No producers valid for 3 frames, `hold_last`=1 after output 0x000010 → outputs stay 0x000010, `underrun_cnt`=3. Repeating with `hold_last`=0 → outputs 0.
- Boundary acceptance: src0 valid at `bc`=62 → ready drops, the sample misses the current commit and appears at the next frame's commit. `underrun_cnt` increments once.
- `rst` asserted at `bc`=30 with both slots full → next cycle: `bc`=0, readys 0, outputs 0, counter 0. After release, the first `lrclk` appears 63 cycles later.
